fexperm_seq: RTL and testbench

- Parametrised, sequential factoradic-to-permutation unranker for N elements, driven by an embedded mixed-radix (factorial-base) counter.
- Converts the digit vector f1..f(N-1) into a permutation of 0..N-1 by performing one insertion level per clock.
- The digit register can be loaded or single-stepped, so the block can enumerate all N! permutations in order.
- Feeds pattern and ordering logic, for example the note/voice order tables in the MIDI path.

---
 rtl/fexperm_pkg.sv | 43 ++++
 rtl/fact_counter.sv | 75 +++++++
 rtl/fexperm_seq.sv | 121 ++++++++++++
 tb/tb_fexperm_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fexperm_pkg.sv
// Shared types and helpers for the factoradic permutation unranker and its counter.
package fexperm_pkg;

  // Widest packed vector any helper has to build (16 elements of 4 bits).
  localparam int MAX_BITS = 64;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_t;

  // Bits needed to index 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    if (bits == 0) bits = 1;
    return bits;
  endfunction

  // LSB offset of slot k (digit or element) in a packed vector of w-bit slots.
  function automatic int slotLsb(input int k, input int w);
    return k * w;
  endfunction

  // Packed identity permutation: slot j holds the value j.
  function automatic logic [MAX_BITS-1:0] identityPerm(input int n, input int w);
    logic [MAX_BITS-1:0] res;
    res = '0;
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < w; b++) begin
        res[slotLsb(j, w) + b] = ((j >> b) & 1) != 0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fact_counter.sv
// Mixed-radix (factorial base) counter: digit k counts 0..k, digit 0 is always 0.
// Supports saturating load, single step and a one-cycle wrap pulse on rollover.
module fact_counter
  import fexperm_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_load_en,
  input  logic [N*W-1:0] i_load_digits,
  input  logic           i_step,
  output logic [N*W-1:0] o_digits,
  output logic           o_wrap
);

  logic [N*W-1:0] r_digits;
  logic           r_wrap;
  logic [N*W-1:0] w_loaded;
  logic [N*W-1:0] w_stepped;
  logic           w_carry;
  logic           w_unused_digit0;

  // Digit 0 of the load vector carries no information and is discarded.
  assign w_unused_digit0 = ^i_load_digits[W-1:0];

  // Clamp each incoming digit to its radix limit so the register never holds an illegal value.
  always_comb begin
    w_loaded = '0;
    for (int k = 1; k < N; k++) begin
      if (i_load_digits[slotLsb(k, W) +: W] > W'(k)) begin
        w_loaded[slotLsb(k, W) +: W] = W'(k);
      end else begin
        w_loaded[slotLsb(k, W) +: W] = i_load_digits[slotLsb(k, W) +: W];
      end
    end
  end

  // Ripple +1 from digit 1 upward; a carry left over after the top digit means rollover to zero.
  always_comb begin
    w_stepped = '0;
    w_carry   = 1'b1;
    for (int k = 1; k < N; k++) begin
      if (!w_carry) begin
        w_stepped[slotLsb(k, W) +: W] = r_digits[slotLsb(k, W) +: W];
      end else if (r_digits[slotLsb(k, W) +: W] == W'(k)) begin
        w_stepped[slotLsb(k, W) +: W] = '0;
      end else begin
        w_stepped[slotLsb(k, W) +: W] = r_digits[slotLsb(k, W) +: W] + W'(1);
        w_carry = 1'b0;
      end
    end
  end

  // Load beats step; wrap is registered so it pulses in the cycle after the rolling step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_load_en) begin
        r_digits <= w_loaded;
      end else if (i_step) begin
        r_digits <= w_stepped;
        r_wrap   <= w_carry;
      end
    end
  end

  assign o_digits = r_digits;
  assign o_wrap   = r_wrap;

endmodule

// File: rtl/fexperm_seq.sv
// Sequential factoradic-to-permutation unranker: one swap level per clock over a
// snapshot of the counter digits, optionally auto-stepping to enumerate all N! orders.
module fexperm_seq
  import fexperm_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_en,
  input  logic [N*W-1:0] load_digits,
  input  logic           step,
  input  logic           start,
  input  logic           auto_run,
  output logic           busy,
  output logic           done,
  output logic           wrap,
  output logic [N*W-1:0] digits_out,
  output logic [N*W-1:0] perm_out
);

  localparam logic [MAX_BITS-1:0] IDENT_FULL = identityPerm(N, W);
  localparam logic [N*W-1:0]      IDENT      = IDENT_FULL[N*W-1:0];

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_lvl;
  logic [N*W-1:0] r_snap;
  logic [W-1:0]   r_work [N];
  logic [N*W-1:0] r_perm;
  logic           r_done;
  logic           r_restart;

  logic           w_setup;
  logic           w_last;
  logic           w_intStep;
  logic [W-1:0]   w_fk;
  logic [W-1:0]   w_partner;
  logic [W-1:0]   w_swapped [N];
  logic [N*W-1:0] w_swappedPacked;

  fact_counter #(
    .N(N)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .i_load_en    (load_en),
    .i_load_digits(load_digits),
    .i_step       (step | w_intStep),
    .o_digits     (digits_out),
    .o_wrap       (wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // A pending auto-run restart acts like start; RUN ends after the top level.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start || r_restart) w_nextState = RUN;
      RUN:     if (w_last)             w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Control decodes; the internal step lands on the final level so the next setup sees fresh digits.
  always_comb begin
    w_setup   = (r_state == IDLE) && (start || r_restart);
    w_last    = (r_state == RUN) && (r_lvl == W'(N - 1));
    w_intStep = w_last && auto_run;
    busy      = (r_state == RUN);
  end

  // Level k swaps positions k and k-f_k; equal indices leave the array untouched.
  always_comb begin
    w_fk      = r_snap[slotLsb(int'(r_lvl), W) +: W];
    w_partner = r_lvl - w_fk;
    for (int j = 0; j < N; j++) w_swapped[j] = r_work[j];
    w_swapped[r_lvl]     = r_work[w_partner];
    w_swapped[w_partner] = r_work[r_lvl];
    w_swappedPacked = '0;
    for (int j = 0; j < N; j++) w_swappedPacked[slotLsb(j, W) +: W] = w_swapped[j];
  end

  // Conversion datapath: setup snapshots digits, RUN applies one level per edge, last level publishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lvl     <= '0;
      r_snap    <= '0;
      r_perm    <= IDENT;
      r_done    <= 1'b0;
      r_restart <= 1'b0;
      for (int j = 0; j < N; j++) r_work[j] <= W'(j);
    end else begin
      r_done <= 1'b0;
      if (w_setup) begin
        r_snap    <= digits_out;
        r_lvl     <= W'(1);
        r_restart <= 1'b0;
        for (int j = 0; j < N; j++) r_work[j] <= W'(j);
      end else if (r_state == RUN) begin
        for (int j = 0; j < N; j++) r_work[j] <= w_swapped[j];
        r_lvl <= r_lvl + W'(1);
        if (w_last) begin
          r_perm    <= w_swappedPacked;
          r_done    <= 1'b1;
          r_restart <= auto_run;
        end
      end
    end
  end

  assign done     = r_done;
  assign perm_out = r_perm;

endmodule

// File: tb/tb_fexperm_seq.sv
// Self-checking bench for fexperm_seq: an N=8 and an N=4 instance share one clock and
// are compared against a rank-based model of the factoradic counter and the unranking rule.
module tb_fexperm_seq;

  logic clk;
  logic reset8, loadEn8, step8, start8, autoRun8, busy8, done8, wrap8;
  logic [23:0] loadDigits8, digitsOut8, permOut8;
  logic reset4, loadEn4, step4, start4, autoRun4, busy4, done4, wrap4;
  logic [7:0] loadDigits4, digitsOut4, permOut4;

  int nChecks = 0;
  int nPass   = 0;

  fexperm_seq #(.N(8)) dut8 (
    .clk(clk), .reset(reset8), .load_en(loadEn8), .load_digits(loadDigits8),
    .step(step8), .start(start8), .auto_run(autoRun8), .busy(busy8), .done(done8),
    .wrap(wrap8), .digits_out(digitsOut8), .perm_out(permOut8)
  );

  fexperm_seq #(.N(4)) dut4 (
    .clk(clk), .reset(reset4), .load_en(loadEn4), .load_digits(loadDigits4),
    .step(step4), .start(start4), .auto_run(autoRun4), .busy(busy4), .done(done4),
    .wrap(wrap4), .digits_out(digitsOut4), .perm_out(permOut4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Digit k of a packed w-bit digit vector.
  function automatic int digitAt(int w, logic [63:0] v, int k);
    return int'((v >> (k * w)) & ((64'd1 << w) - 64'd1));
  endfunction

  // Insertion-by-swap unranking on a plain integer array.
  function automatic logic [63:0] modelPerm(int n, int w, logic [63:0] digs);
    int a[16];
    int f, t;
    logic [63:0] res;
    for (int j = 0; j < 16; j++) a[j] = j;
    for (int k = 1; k < n; k++) begin
      f = digitAt(w, digs, k);
      t = a[k];
      a[k] = a[k-f];
      a[k-f] = t;
    end
    res = '0;
    for (int j = 0; j < n; j++) res = res | (64'(a[j]) << (j * w));
    return res;
  endfunction

  // Rank (0..n!-1) to factorial-base digits, digit 1 least significant.
  function automatic logic [63:0] rankToDigits(int n, int w, int rank);
    logic [63:0] res;
    int r;
    r = rank;
    res = '0;
    for (int k = 1; k < n; k++) begin
      res = res | (64'(r % (k + 1)) << (k * w));
      r = r / (k + 1);
    end
    return res;
  endfunction

  function automatic logic [63:0] saturate(int n, int w, logic [63:0] d);
    logic [63:0] res;
    int dig;
    res = '0;
    for (int k = 1; k < n; k++) begin
      dig = digitAt(w, d, k);
      if (dig > k) dig = k;
      res = res | (64'(dig) << (k * w));
    end
    return res;
  endfunction

  function automatic logic [63:0] packList(int n, int w, int e[16]);
    logic [63:0] res;
    res = '0;
    for (int j = 0; j < n; j++) res = res | (64'(e[j]) << (j * w));
    return res;
  endfunction

  task automatic resetAll();
    reset8 = 1'b1; loadEn8 = 1'b0; step8 = 1'b0; start8 = 1'b0; autoRun8 = 1'b0; loadDigits8 = '0;
    reset4 = 1'b1; loadEn4 = 1'b0; step4 = 1'b0; start4 = 1'b0; autoRun4 = 1'b0; loadDigits4 = '0;
    repeat (2) @(negedge clk);
    reset8 = 1'b0;
    reset4 = 1'b0;
  endtask

  task automatic load8(input logic [23:0] d);
    loadDigits8 = d; loadEn8 = 1'b1;
    @(negedge clk);
    loadEn8 = 1'b0;
  endtask

  task automatic load4(input logic [7:0] d);
    loadDigits4 = d; loadEn4 = 1'b1;
    @(negedge clk);
    loadEn4 = 1'b0;
  endtask

  // Pulse start, then count samples until done; returns at the done sample.
  task automatic convert8(output logic [23:0] perm, output int lat, output int busyCnt, output bit timedOut);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; busyCnt = 0; timedOut = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done8) begin
        timedOut = 1'b0;
        break;
      end
      if (busy8) busyCnt++;
      lat++;
      @(negedge clk);
    end
    perm = permOut8;
  endtask

  task automatic convert4(output logic [7:0] perm, output bit timedOut);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    timedOut = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done4) begin
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    perm = permOut4;
  endtask

  task automatic test_reset();
    logic [63:0] e64;
    logic [23:0] e8;
    logic [7:0]  e4;
    resetAll();
    e64 = modelPerm(8, 3, 64'd0); e8 = e64[23:0];
    e64 = modelPerm(4, 2, 64'd0); e4 = e64[7:0];
    nChecks++; if (busy8 !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy8); else nPass++;
    nChecks++; if (done8 !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", done8); else nPass++;
    nChecks++; if (wrap8 !== 1'b0) $display("[TB] FAIL reset_wrap: got %0b want 0", wrap8); else nPass++;
    nChecks++; if (digitsOut8 !== 24'd0) $display("[TB] FAIL reset_digits8: got %0h want 0", digitsOut8); else nPass++;
    nChecks++; if (permOut8 !== e8) $display("[TB] FAIL reset_perm8: got %0h want %0h", permOut8, e8); else nPass++;
    nChecks++; if (permOut4 !== e4) $display("[TB] FAIL reset_perm4: got %0h want %0h", permOut4, e4); else nPass++;
    nChecks++; if (busy4 !== 1'b0) $display("[TB] FAIL reset_busy4: got %0b want 0", busy4); else nPass++;
  endtask

  task automatic test_directed8();
    logic [23:0] d, perm, e8, m8;
    logic [63:0] e64;
    int lit[16];
    int lat, busyCnt;
    bit timedOut;
    resetAll();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin d = 24'd0;            lit = '{0,1,2,3,4,5,6,7,0,0,0,0,0,0,0,0}; end
        1:       begin d = 24'(1) << 3;      lit = '{1,0,2,3,4,5,6,7,0,0,0,0,0,0,0,0}; end
        default: begin d = 24'(7) << 21;     lit = '{7,1,2,3,4,5,6,0,0,0,0,0,0,0,0,0}; end
      endcase
      e64 = packList(8, 3, lit); e8 = e64[23:0];
      e64 = modelPerm(8, 3, 64'(d)); m8 = e64[23:0];
      load8(d);
      convert8(perm, lat, busyCnt, timedOut);
      nChecks++; if (timedOut !== 1'b0) $display("[TB] FAIL dir_timeout[%0d]: no done within budget", i); else nPass++;
      nChecks++; if (lat !== 7) $display("[TB] FAIL dir_latency[%0d]: got %0d want 7", i, lat); else nPass++;
      nChecks++; if (busyCnt !== 7) $display("[TB] FAIL dir_busy_cycles[%0d]: got %0d want 7", i, busyCnt); else nPass++;
      nChecks++; if (busy8 !== 1'b0) $display("[TB] FAIL dir_busy_at_done[%0d]: got %0b want 0", i, busy8); else nPass++;
      nChecks++; if (perm !== e8) $display("[TB] FAIL dir_perm[%0d]: got %0h want %0h", i, perm, e8); else nPass++;
      nChecks++; if (perm !== m8) $display("[TB] FAIL dir_model[%0d]: got %0h want %0h", i, perm, m8); else nPass++;
      @(negedge clk);
      nChecks++; if (done8 !== 1'b0) $display("[TB] FAIL dir_done_width[%0d]: got %0b want 0", i, done8); else nPass++;
      nChecks++; if (permOut8 !== e8) $display("[TB] FAIL dir_perm_hold[%0d]: got %0h want %0h", i, permOut8, e8); else nPass++;
    end
  endtask

  task automatic test_random8();
    logic [23:0] d, sat, perm, e8;
    logic [63:0] e64;
    int lat, busyCnt;
    bit timedOut;
    resetAll();
    for (int i = 0; i < 8; i++) begin
      d = 24'($urandom);
      e64 = saturate(8, 3, 64'(d)); sat = e64[23:0];
      e64 = modelPerm(8, 3, 64'(sat)); e8 = e64[23:0];
      load8(d);
      nChecks++; if (digitsOut8 !== sat) $display("[TB] FAIL rnd_load[%0d]: got %0h want %0h", i, digitsOut8, sat); else nPass++;
      convert8(perm, lat, busyCnt, timedOut);
      nChecks++; if (timedOut !== 1'b0) $display("[TB] FAIL rnd_timeout[%0d]: no done within budget", i); else nPass++;
      nChecks++; if (perm !== e8) $display("[TB] FAIL rnd_perm[%0d]: got %0h want %0h", i, perm, e8); else nPass++;
      @(negedge clk);
    end
  endtask

  task automatic test_step_wrap4();
    logic [7:0] perm, e4, d4;
    logic [63:0] e64;
    int lit[16];
    int r;
    bit timedOut;
    resetAll();
    lit = '{3,0,1,2,0,0,0,0,0,0,0,0,0,0,0,0};
    e64 = packList(4, 2, lit); e4 = e64[7:0];
    load4(8'hE4);
    convert4(perm, timedOut);
    nChecks++; if (timedOut !== 1'b0) $display("[TB] FAIL n4_timeout: no done within budget"); else nPass++;
    nChecks++; if (perm !== e4) $display("[TB] FAIL n4_perm: got %0h want %0h", perm, e4); else nPass++;
    step4 = 1'b1;
    @(negedge clk);
    step4 = 1'b0;
    nChecks++; if (digitsOut4 !== 8'd0) $display("[TB] FAIL n4_step_zero: got %0h want 0", digitsOut4); else nPass++;
    nChecks++; if (wrap4 !== 1'b1) $display("[TB] FAIL n4_wrap_pulse: got %0b want 1", wrap4); else nPass++;
    @(negedge clk);
    nChecks++; if (wrap4 !== 1'b0) $display("[TB] FAIL n4_wrap_width: got %0b want 0", wrap4); else nPass++;
    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 23 : int'($urandom_range(0, 22));
      e64 = rankToDigits(4, 2, r); d4 = e64[7:0];
      load4(d4);
      step4 = 1'b1;
      @(negedge clk);
      step4 = 1'b0;
      e64 = rankToDigits(4, 2, (r + 1) % 24); d4 = e64[7:0];
      nChecks++; if (digitsOut4 !== d4) $display("[TB] FAIL step_digits[r=%0d]: got %0h want %0h", r, digitsOut4, d4); else nPass++;
      nChecks++; if (wrap4 !== (r == 23)) $display("[TB] FAIL step_wrap[r=%0d]: got %0b want %0b", r, wrap4, (r == 23)); else nPass++;
    end
  endtask

  task automatic test_priority4();
    logic [7:0] x, sat, first;
    logic [63:0] e64;
    resetAll();
    load4(8'h30);
    nChecks++; if (digitsOut4 !== 8'h20) $display("[TB] FAIL sat_digit2: got %0h want 20", digitsOut4); else nPass++;
    for (int i = 0; i < 4; i++) begin
      first = 8'($urandom);
      load4(first);
      x = 8'($urandom);
      e64 = saturate(4, 2, 64'(x)); sat = e64[7:0];
      loadDigits4 = x; loadEn4 = 1'b1; step4 = 1'b1;
      @(negedge clk);
      loadEn4 = 1'b0; step4 = 1'b0;
      nChecks++; if (digitsOut4 !== sat) $display("[TB] FAIL load_beats_step[%0d]: got %0h want %0h", i, digitsOut4, sat); else nPass++;
      nChecks++; if (wrap4 !== 1'b0) $display("[TB] FAIL load_step_wrap[%0d]: got %0b want 0", i, wrap4); else nPass++;
    end
  endtask

  task automatic test_auto_run4();
    logic [7:0] seen[24];
    logic [7:0] e4;
    logic [63:0] e64;
    int cyc, cnt, lastDone, wraps, wrapAt, dups;
    resetAll();
    autoRun4 = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0; cnt = 0; lastDone = 0; wraps = 0; wrapAt = -1; dups = 0;
    while (cnt < 28 && cyc < 200) begin
      if (wrap4) begin
        wraps++;
        if (done4) wrapAt = cnt + 1;
      end
      if (done4) begin
        cnt++;
        e64 = modelPerm(4, 2, rankToDigits(4, 2, (cnt - 1) % 24)); e4 = e64[7:0];
        nChecks++; if (permOut4 !== e4) $display("[TB] FAIL auto_perm[%0d]: got %0h want %0h", cnt, permOut4, e4); else nPass++;
        if (cnt > 1) begin
          nChecks++; if (cyc - lastDone !== 4) $display("[TB] FAIL auto_period[%0d]: got %0d want 4", cnt, cyc - lastDone); else nPass++;
        end
        lastDone = cyc;
        if (cnt <= 24) begin
          for (int p = 0; p < cnt - 1; p++) if (seen[p] == permOut4) dups++;
          seen[cnt-1] = permOut4;
        end
      end
      if (cnt < 28) begin
        @(negedge clk);
        cyc++;
      end
    end
    autoRun4 = 1'b0;
    nChecks++; if (cnt !== 28) $display("[TB] FAIL auto_count: got %0d want 28", cnt); else nPass++;
    nChecks++; if (wraps !== 1) $display("[TB] FAIL auto_wraps: got %0d want 1", wraps); else nPass++;
    nChecks++; if (wrapAt !== 24) $display("[TB] FAIL auto_wrap_index: got %0d want 24", wrapAt); else nPass++;
    nChecks++; if (dups !== 0) $display("[TB] FAIL auto_distinct: got %0d duplicates want 0", dups); else nPass++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_abort8();
    logic [23:0] perm, e8, id8;
    logic [63:0] e64;
    int lat, busyCnt, dones;
    bit timedOut;
    resetAll();
    e64 = modelPerm(8, 3, 64'd0); id8 = e64[23:0];
    e64 = modelPerm(8, 3, 64'(24'(7) << 21)); e8 = e64[23:0];
    load8(24'(7) << 21);
    convert8(perm, lat, busyCnt, timedOut);
    nChecks++; if (perm !== e8) $display("[TB] FAIL abort_pre_perm: got %0h want %0h", perm, e8); else nPass++;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++; if (busy8 !== 1'b1) $display("[TB] FAIL abort_busy_before: got %0b want 1", busy8); else nPass++;
    reset8 = 1'b1;
    @(negedge clk);
    nChecks++; if (busy8 !== 1'b0) $display("[TB] FAIL abort_busy: got %0b want 0", busy8); else nPass++;
    nChecks++; if (done8 !== 1'b0) $display("[TB] FAIL abort_done: got %0b want 0", done8); else nPass++;
    nChecks++; if (permOut8 !== id8) $display("[TB] FAIL abort_perm: got %0h want %0h", permOut8, id8); else nPass++;
    nChecks++; if (digitsOut8 !== 24'd0) $display("[TB] FAIL abort_digits: got %0h want 0", digitsOut8); else nPass++;
    reset8 = 1'b0;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    nChecks++; if (dones !== 0) $display("[TB] FAIL abort_no_done: got %0d want 0", dones); else nPass++;
  endtask

  task automatic test_back_to_back8();
    logic [23:0] d1, d2, sat1, sat2, e8, perm;
    logic [63:0] e64;
    int dones;
    resetAll();
    d1 = 24'($urandom);
    d2 = 24'($urandom);
    e64 = saturate(8, 3, 64'(d1)); sat1 = e64[23:0];
    e64 = saturate(8, 3, 64'(d2)); sat2 = e64[23:0];
    e64 = modelPerm(8, 3, 64'(sat1)); e8 = e64[23:0];
    load8(d1);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; loadDigits8 = d2; loadEn8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; loadEn8 = 1'b0;
    dones = 0;
    perm = '0;
    for (int c = 0; c < 24; c++) begin
      if (done8) begin
        dones++;
        perm = permOut8;
      end
      @(negedge clk);
    end
    nChecks++; if (dones !== 1) $display("[TB] FAIL b2b_done_count: got %0d want 1", dones); else nPass++;
    nChecks++; if (perm !== e8) $display("[TB] FAIL b2b_snapshot_perm: got %0h want %0h", perm, e8); else nPass++;
    nChecks++; if (digitsOut8 !== sat2) $display("[TB] FAIL b2b_load_in_run: got %0h want %0h", digitsOut8, sat2); else nPass++;
  endtask

  initial begin
    test_reset();
    test_directed8();
    test_random8();
    test_step_wrap4();
    test_priority4();
    test_auto_run4();
    test_reset_abort8();
    test_back_to_back8();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
